// File: rtl/cache_controller.sv
// 2-way set-associative, write-through, no-write-allocate data cache in front of an SRAM controller.
// Optional hit/miss statistics counters are built when CACHE_STATS_EN is defined.
module cache_controller (
    input  logic        clk,
    input  logic        rst,
    input  logic        MEM_R_EN,
    input  logic        MEM_W_EN,
    input  logic [31:0] address,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        ready,
    output logic [31:0] sram_address,
    output logic [31:0] sram_wdata,
    output logic        sram_rd_en,
    output logic        sram_wr_en,
    input  logic [63:0] sram_rdata,
    input  logic        sram_ready,
    output logic [31:0] hit_count,
    output logic [31:0] miss_count
);

    // state     | meaning
    // IDLE      | no SRAM access; read hits served combinationally
    // READ_MISS | block fetch from SRAM, fill into the LRU way on sram_ready
    // WRITE     | write-through to SRAM; update the cached word on a hit
    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        READ_MISS = 2'd1,
        WRITE     = 2'd2
    } state_t;

    state_t state;

    logic [31:0] ea;
    logic        word_sel;
    logic [5:0]  set_idx;
    logic [9:0]  tag;

    assign ea       = address - 32'd1024;
    assign word_sel = ea[2];
    assign set_idx  = ea[8:3];
    assign tag      = ea[18:9];

    logic [63:0] valid0;
    logic [63:0] valid1;
    logic [63:0] lru;
    logic [9:0]  tag0  [64];
    logic [9:0]  tag1  [64];
    logic [63:0] data0 [64];
    logic [63:0] data1 [64];

    logic        hit0;
    logic        hit1;
    logic        hit;
    logic [63:0] hit_block;
    logic [31:0] hit_word;
    logic [31:0] fill_word;

    assign hit0      = valid0[set_idx] && (tag0[set_idx] == tag);
    assign hit1      = valid1[set_idx] && (tag1[set_idx] == tag);
    assign hit       = hit0 || hit1;
    assign hit_block = hit1 ? data1[set_idx] : data0[set_idx];
    assign hit_word  = word_sel ? hit_block[63:32] : hit_block[31:0];
    assign fill_word = word_sel ? sram_rdata[63:32] : sram_rdata[31:0];

    logic rd_hit_ev;
    logic rd_fill_ev;
    logic wr_hit_ev;

    // A write outranks a simultaneous read, so a read only counts with MEM_W_EN low.
    assign rd_hit_ev  = (state == IDLE) && MEM_R_EN && !MEM_W_EN && hit;
    assign rd_fill_ev = (state == READ_MISS) && sram_ready;
    assign wr_hit_ev  = (state == WRITE) && sram_ready && hit;

    always_comb begin
        ready        = 1'b0;
        rdata        = '0;
        sram_address = '0;
        sram_wdata   = '0;
        sram_rd_en   = 1'b0;
        sram_wr_en   = 1'b0;
        case (state)
            IDLE: begin
                if (MEM_W_EN) begin
                    ready = 1'b0;
                end else if (MEM_R_EN) begin
                    if (hit) begin
                        ready = 1'b1;
                        rdata = hit_word;
                    end
                end else begin
                    ready = 1'b1;
                end
            end
            READ_MISS: begin
                sram_rd_en   = 1'b1;
                sram_address = {ea[31:3], 3'b000};
                if (sram_ready) begin
                    ready = 1'b1;
                    rdata = fill_word;
                end
            end
            WRITE: begin
                sram_wr_en   = 1'b1;
                sram_address = ea;
                sram_wdata   = wdata;
                ready        = sram_ready;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            valid0 <= '0;
            valid1 <= '0;
            lru    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (MEM_W_EN)
                        state <= WRITE;
                    else if (MEM_R_EN && !hit)
                        state <= READ_MISS;
                end
                READ_MISS: if (sram_ready) state <= IDLE;
                WRITE:     if (sram_ready) state <= IDLE;
                default:   state <= IDLE;
            endcase
            // LRU names the way not just used: the other way of a hit.
            if (rd_hit_ev || wr_hit_ev)
                lru[set_idx] <= hit0;
            if (rd_fill_ev) begin
                lru[set_idx] <= ~lru[set_idx];
                if (lru[set_idx])
                    valid1[set_idx] <= 1'b1;
                else
                    valid0[set_idx] <= 1'b1;
            end
        end
    end

    // Tag/data storage is not reset; reset only blocks updates of an aborted access.
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (rd_fill_ev) begin
                if (lru[set_idx]) begin
                    tag1[set_idx]  <= tag;
                    data1[set_idx] <= sram_rdata;
                end else begin
                    tag0[set_idx]  <= tag;
                    data0[set_idx] <= sram_rdata;
                end
            end
            if (wr_hit_ev) begin
                if (hit1)
                    data1[set_idx][{word_sel, 5'b00000} +: 32] <= wdata;
                else
                    data0[set_idx][{word_sel, 5'b00000} +: 32] <= wdata;
            end
        end
    end

`ifdef CACHE_STATS_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            hit_count  <= '0;
            miss_count <= '0;
        end else begin
            if (rd_hit_ev)
                hit_count <= hit_count + 32'd1;
            if (rd_fill_ev)
                miss_count <= miss_count + 32'd1;
        end
    end
`else
    assign hit_count  = '0;
    assign miss_count = '0;
`endif

endmodule
